rs_dispatch_arbiter: RTL and testbench
======================================

// Module: rs_dispatch_arbiter
// PURPOSE
//  Distributes one renamed dispatch group (up to DISPATCH_WIDTH instrs) across the BANK_NUM
//  write ports of one reservation station. Registers the group, places in-order-prefix slots
//  onto ready banks in rotating order, and back-pressures rename until the group is drained.
//  Sits between rename/dispatch and the reservation-station write ports (wr_valid/wr_ready).
// PARAMETERS
//  DISPATCH_WIDTH  `DECODE_WIDTH  slots per dispatch group
//  BANK_NUM        2              RS banks, one write port each
//  OPTION_CODE     OptionCodeSt   FU option-code type, passed through untouched
// PORTS
//  clk            in   1                          clock
//  a_rst_n        in   1                          async reset, active low
//  flush_i        in   1                          pipeline flush, synchronous
//  dis_valid_i    in   DISPATCH_WIDTH             per-slot valid of incoming group
//  dis_base_i     in   DISPATCH_WIDTH x RsBaseSt  per-slot RS entry base
//  dis_oc_i       in   DISPATCH_WIDTH x OPTION_CODE per-slot option code
//  dis_ready_o    out  1                          group accepted when any dis_valid_i & dis_ready_o
//  rs_wr_valid_o  out  BANK_NUM                   bank write request
//  rs_wr_ready_i  in   BANK_NUM                   bank has a free entry
//  rs_base_o      out  BANK_NUM x RsBaseSt        base driven to bank
//  rs_oc_o        out  BANK_NUM x OPTION_CODE     option code driven to bank
// BEHAVIOUR
//  - State: grp_q (slot payloads), pend_q[DISPATCH_WIDTH] (slots not yet placed), rr_q (bank ptr,
//    width max(1,$clog2(BANK_NUM))). Reset (a_rst_n low): pend_q=0, rr_q=0, grp_q=0.
//  - Outputs after reset: rs_wr_valid_o=0, rs_base_o/rs_oc_o=0, dis_ready_o=1.
//  - Placement (comb, per cycle): banks ordered rr_q, rr_q+1, ... mod BANK_NUM; keep only those
//    with rs_wr_ready_i=1. Pending slots taken in ascending slot index. n-th pending slot goes to
//    n-th ready bank. Slot order is preserved: a slot is placed only if every lower pending slot
//    is placed in the same cycle. Unplaced slots stay pending; no slot is written twice.
//  - rs_wr_valid_o[b]=1 only for banks given a slot; payload = that slot's grp_q entry. Unused
//    banks: valid=0, payload don't-care (drive 0). Never depends on rs_wr_ready_i of other banks
//    beyond the placement rule above.
//  - Handshake: a placement is a completed write (bank ready was sampled). pend_q clears placed bits.
//  - rr_q <= (last bank used + 1) mod BANK_NUM when >=1 placement; unchanged otherwise.
//  - dis_ready_o = (pend_q==0) | (all pending slots placed this cycle). On accept, grp_q<=dis_*_i,
//    pend_q<=dis_valid_i (holes allowed; invalid slots never issued). Latency accept->first
//    write: 1 cycle. Group of zero valid slots is not a transfer.
//  - Back-to-back: last slots of group N and accept of group N+1 in the same cycle is legal.
//  - flush_i=1: rs_wr_valid_o forced 0 that cycle, dis_ready_o=0, next pend_q=0, rr_q=0; no
//    accept. Flush dominates simultaneous accept and placements.
//  - All banks not ready: no placement, state held, dis_ready_o=0 if pend_q!=0.
//  - Reset mid-drain: pending slots discarded, no partial write survives.
//  - BANK_NUM=1 legal: rr_q stuck at 0, one slot per cycle.
//  - Assertions: at most one slot per bank per cycle; placed slot indices form a contiguous
//    prefix of pending slots; rs_wr_valid_o & ~rs_wr_ready_i == 0.
// STRUCTURE
//  - Scheduler.svh: DispatchSlotSt {RsBaseSt base} (oc stays parametric in the module);
//    localparam RR_W helper. No new globals in config.svh.
//  - One sub-module: rr_bank_picker (rotate ready mask by rr_q, produce ordered bank list and
//    count; purely combinational, BANK_NUM param). Rest (grp/pend/rr regs) in top.
// TESTING
//  - Reset, then idle: rs_wr_valid_o=0, dis_ready_o=1, rr_q=0.
//  - DW=2,BANK=2, all ready, group {A,B}: cycle+1 A->bank0, B->bank1, dis_ready_o=1, rr_q=0.
//  - Same group, rs_wr_ready_i=2'b10: A->bank1 only, B pending, dis_ready_o=0; next cycle
//    ready=2'b11, B->bank0 (rr_q=0), dis_ready_o=1.
//  - Group {A,B}, ready=2'b00 for 3 cycles: no writes, dis_ready_o=0, grp held; then 2'b11 drains.
//  - dis_valid_i=2'b10 (hole at slot0): only slot1 written, to bank rr_q; slot0 never appears.
//  - Flush with B pending and new group valid: no write that cycle, next cycle pend=0, rr_q=0,
//    dis_ready_o=1; new group not accepted.

Source files
------------

// File: rtl/rs_dispatch_arbiter_pkg.sv
// Shared types for the reservation-station dispatch arbiter: slot payload,
// default option-code type and the round-robin pointer width helper.
package rs_dispatch_arbiter_pkg;

  localparam int DECODE_WIDTH = 2;

  typedef struct packed {
    logic [5:0] rob_id;
    logic [6:0] prd;
  } rs_base_t;

  typedef struct packed {
    rs_base_t base;
  } dispatch_slot_t;

  typedef logic [7:0] option_code_t;

  function automatic int rr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs_dispatch_arbiter_checker.sv
// Protocol checks for the dispatch arbiter: one slot per bank, in-order
// prefix placement, and no write to a bank that is not ready.
module rs_dispatch_arbiter_checker #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int BANK_NUM       = 2,
  parameter int RR_W           = 1
) (
  input logic                                clk,
  input logic                                a_rst_n,
  input logic [DISPATCH_WIDTH-1:0]           pend,
  input logic [DISPATCH_WIDTH-1:0]           placed,
  input logic [DISPATCH_WIDTH-1:0][RR_W-1:0] slot_bank,
  input logic [BANK_NUM-1:0]                 wr_valid,
  input logic [BANK_NUM-1:0]                 wr_ready
);

  logic unique_bank_s;
  logic prefix_s;

  // Evaluate bank uniqueness and prefix ordering of this cycle's placements
  always_comb begin
    unique_bank_s = 1'b1;
    prefix_s      = ((placed & ~pend) == '0);
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      for (int t = 0; t < s; t++) begin
        if (placed[s] && placed[t] && (slot_bank[s] == slot_bank[t])) begin
          unique_bank_s = 1'b0;
        end else begin
          unique_bank_s = unique_bank_s;
        end
        if (placed[s] && pend[t] && !placed[t]) begin
          prefix_s = 1'b0;
        end else begin
          prefix_s = prefix_s;
        end
      end
    end
  end

  a_one_slot_per_bank: assert property (@(posedge clk) disable iff (!a_rst_n) unique_bank_s);
  a_prefix_order:      assert property (@(posedge clk) disable iff (!a_rst_n) prefix_s);
  a_write_when_ready:  assert property (@(posedge clk) disable iff (!a_rst_n)
                                        ((wr_valid & ~wr_ready) == '0));

endmodule

// File: rtl/rs_dispatch_arbiter_rr_bank_picker.sv
// Rotates the bank ready mask by the round-robin pointer and lists the ready
// banks in service order, together with how many there are.
module rr_bank_picker
  import rs_dispatch_arbiter_pkg::*;
#(
  parameter int BANK_NUM = 2,
  parameter int RR_W     = rr_width(BANK_NUM),
  parameter int CNT_W    = $clog2(BANK_NUM + 1)
) (
  input  logic [BANK_NUM-1:0]           ready,
  input  logic [RR_W-1:0]               rr,
  output logic [BANK_NUM-1:0][RR_W-1:0] bank_list,
  output logic [CNT_W-1:0]              bank_cnt
);

  // Walk banks rr, rr+1, ... and append each ready one to the list
  always_comb begin
    logic [RR_W:0] idx_s;
    logic          rdy_s;
    int            n_s;
    bank_list = '0;
    bank_cnt  = '0;
    idx_s     = '0;
    rdy_s     = 1'b0;
    n_s       = 0;
    for (int i = 0; i < BANK_NUM; i++) begin
      idx_s = {1'b0, rr} + (RR_W + 1)'(i);
      if (idx_s >= (RR_W + 1)'(BANK_NUM)) begin
        idx_s = idx_s - (RR_W + 1)'(BANK_NUM);
      end else begin
        idx_s = idx_s;
      end
      rdy_s = 1'b0;
      for (int j = 0; j < BANK_NUM; j++) begin
        rdy_s = ((RR_W + 1)'(j) == idx_s) ? ready[j] : rdy_s;
      end
      if (rdy_s) begin
        for (int k = 0; k < BANK_NUM; k++) begin
          bank_list[k] = (k == n_s) ? idx_s[RR_W-1:0] : bank_list[k];
        end
        n_s = n_s + 1;
      end else begin
        n_s = n_s;
      end
    end
    bank_cnt = CNT_W'(n_s);
  end

endmodule

// File: rtl/rs_dispatch_arbiter.sv
// Registers one dispatch group and spreads its pending slots, in slot order,
// over the ready reservation-station banks in rotating order.
module rs_dispatch_arbiter
  import rs_dispatch_arbiter_pkg::*;
#(
  parameter int  DISPATCH_WIDTH = DECODE_WIDTH,
  parameter int  BANK_NUM       = 2,
  parameter type OPTION_CODE    = option_code_t
) (
  input  logic                            clk,
  input  logic                            a_rst_n,
  input  logic                            flush_i,
  input  logic       [DISPATCH_WIDTH-1:0] dis_valid_i,
  input  rs_base_t   [DISPATCH_WIDTH-1:0] dis_base_i,
  input  OPTION_CODE [DISPATCH_WIDTH-1:0] dis_oc_i,
  output logic                            dis_ready_o,
  output logic       [BANK_NUM-1:0]       rs_wr_valid_o,
  input  logic       [BANK_NUM-1:0]       rs_wr_ready_i,
  output rs_base_t   [BANK_NUM-1:0]       rs_base_o,
  output OPTION_CODE [BANK_NUM-1:0]       rs_oc_o
);

  localparam int RR_W  = rr_width(BANK_NUM);
  localparam int CNT_W = $clog2(BANK_NUM + 1);

  dispatch_slot_t [DISPATCH_WIDTH-1:0] grp_q;
  OPTION_CODE     [DISPATCH_WIDTH-1:0] grp_oc_q;
  logic           [DISPATCH_WIDTH-1:0] pend_q;
  logic           [RR_W-1:0]           rr_q;

  logic [BANK_NUM-1:0][RR_W-1:0]       bank_list_s;
  logic [CNT_W-1:0]                    bank_cnt_s;
  logic [DISPATCH_WIDTH-1:0]           placed_s;
  logic [DISPATCH_WIDTH-1:0][RR_W-1:0] slot_bank_s;
  logic [RR_W-1:0]                     last_bank_s;
  logic [RR_W-1:0]                     rr_next_s;
  logic                                accept_s;

  rr_bank_picker #(
    .BANK_NUM (BANK_NUM),
    .RR_W     (RR_W),
    .CNT_W    (CNT_W)
  ) u_picker (
    .ready     (rs_wr_ready_i),
    .rr        (rr_q),
    .bank_list (bank_list_s),
    .bank_cnt  (bank_cnt_s)
  );

  // Map the n-th pending slot to the n-th ready bank; the first slot that
  // cannot be placed blocks every higher slot so order is preserved.
  always_comb begin
    int   n_s;
    logic stop_s;
    placed_s    = '0;
    slot_bank_s = '0;
    last_bank_s = '0;
    n_s         = 0;
    stop_s      = flush_i;
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      if (pend_q[s]) begin
        if (!stop_s && (n_s < int'(bank_cnt_s))) begin
          placed_s[s] = 1'b1;
          for (int k = 0; k < BANK_NUM; k++) begin
            slot_bank_s[s] = (k == n_s) ? bank_list_s[k] : slot_bank_s[s];
          end
          last_bank_s = slot_bank_s[s];
          n_s         = n_s + 1;
        end else begin
          stop_s = 1'b1;
        end
      end else begin
        stop_s = stop_s;
      end
    end
  end

  // Drive each bank from the slot placed on it, zero when unused
  always_comb begin
    rs_wr_valid_o = '0;
    rs_base_o     = '0;
    rs_oc_o       = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int s = 0; s < DISPATCH_WIDTH; s++) begin
        if (placed_s[s] && (slot_bank_s[s] == RR_W'(b))) begin
          rs_wr_valid_o[b] = 1'b1;
          rs_base_o[b]     = grp_q[s].base;
          rs_oc_o[b]       = grp_oc_q[s];
        end else begin
          rs_wr_valid_o[b] = rs_wr_valid_o[b];
        end
      end
    end
  end

  // Group acceptance and next rotation pointer
  always_comb begin
    dis_ready_o = !flush_i && (placed_s == pend_q);
    accept_s    = dis_ready_o && (|dis_valid_i);
    if (placed_s == '0) begin
      rr_next_s = rr_q;
    end else if (({1'b0, last_bank_s} + {{RR_W{1'b0}}, 1'b1}) >= (RR_W + 1)'(BANK_NUM)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = last_bank_s + RR_W'(1);
    end
  end

  // Group payload, pending mask and rotation pointer
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      grp_q    <= '0;
      grp_oc_q <= '0;
      pend_q   <= '0;
      rr_q     <= '0;
    end else if (flush_i) begin
      pend_q <= '0;
      rr_q   <= '0;
    end else begin
      rr_q <= rr_next_s;
      if (accept_s) begin
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
          grp_q[s].base <= dis_base_i[s];
        end
        grp_oc_q <= dis_oc_i;
        pend_q   <= dis_valid_i;
      end else begin
        pend_q <= pend_q & ~placed_s;
      end
    end
  end

  rs_dispatch_arbiter_checker #(
    .DISPATCH_WIDTH (DISPATCH_WIDTH),
    .BANK_NUM       (BANK_NUM),
    .RR_W           (RR_W)
  ) u_checker (
    .clk       (clk),
    .a_rst_n   (a_rst_n),
    .pend      (pend_q),
    .placed    (placed_s),
    .slot_bank (slot_bank_s),
    .wr_valid  (rs_wr_valid_o),
    .wr_ready  (rs_wr_ready_i)
  );

endmodule

// File: tb/tb_rs_dispatch_arbiter.sv
// Directed scoreboard bench for rs_dispatch_arbiter (DISPATCH_WIDTH=2, BANK_NUM=2).
module tb_rs_dispatch_arbiter;
  import rs_dispatch_arbiter_pkg::*;

  localparam int DW = 2;
  localparam int BN = 2;

  logic                      clk = 1'b0;
  logic                      a_rst_n = 1'b0;
  logic                      flush_i = 1'b0;
  logic         [DW-1:0]     dis_valid_i = '0;
  rs_base_t     [DW-1:0]     dis_base_i = '0;
  option_code_t [DW-1:0]     dis_oc_i = '0;
  logic                      dis_ready_o;
  logic         [BN-1:0]     rs_wr_valid_o;
  logic         [BN-1:0]     rs_wr_ready_i = 2'b11;
  rs_base_t     [BN-1:0]     rs_base_o;
  option_code_t [BN-1:0]     rs_oc_o;

  rs_dispatch_arbiter #(.DISPATCH_WIDTH(DW), .BANK_NUM(BN), .OPTION_CODE(option_code_t)) dut (
    .clk           (clk),
    .a_rst_n       (a_rst_n),
    .flush_i       (flush_i),
    .dis_valid_i   (dis_valid_i),
    .dis_base_i    (dis_base_i),
    .dis_oc_i      (dis_oc_i),
    .dis_ready_o   (dis_ready_o),
    .rs_wr_valid_o (rs_wr_valid_o),
    .rs_wr_ready_i (rs_wr_ready_i),
    .rs_base_o     (rs_base_o),
    .rs_oc_o       (rs_oc_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    int           bank;
    rs_base_t     base;
    option_code_t oc;
  } wr_t;

  wr_t exp_q[$];
  bit  rdy_en[512];
  bit  rdy_val[512];
  int  n_checks = 0;
  int  n_fail = 0;

  function automatic rs_base_t mkb(input int id);
    rs_base_t r;
    r.rob_id = 6'(id);
    r.prd    = 7'(id * 3 + 1);
    return r;
  endfunction

  function automatic option_code_t mkoc(input int id);
    return 8'(id * 17 + 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_grp(input logic [1:0] v, input int id0, input int id1);
    dis_valid_i   = v;
    dis_base_i[0] = mkb(id0);
    dis_base_i[1] = mkb(id1);
    dis_oc_i[0]   = mkoc(id0);
    dis_oc_i[1]   = mkoc(id1);
  endtask

  task automatic exp_wr(input int bank, input int id);
    exp_q.push_back('{cyc, bank, mkb(id), mkoc(id)});
  endtask

  task automatic exp_rdy(input bit r);
    rdy_en[cyc]  = 1'b1;
    rdy_val[cyc] = r;
  endtask

  // Monitor: compare ready against the per-cycle expectation and pop one
  // expected write for every bank the DUT writes
  always @(negedge clk) begin
    wr_t e;
    if (rdy_en[cyc]) check("dis_ready", 32'(dis_ready_o), 32'(rdy_val[cyc]));
    for (int b = 0; b < BN; b++) begin
      if (rs_wr_valid_o[b]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write at cycle %0d: bank %0d base %h, none expected",
                   cyc, b, rs_base_o[b]);
        end else begin
          e = exp_q.pop_front();
          check("wr_cycle", 32'(cyc), 32'(e.cyc));
          check("wr_bank", 32'(b), 32'(e.bank));
          check("wr_base", 32'({rs_base_o[b]}), 32'({e.base}));
          check("wr_oc", 32'(rs_oc_o[b]), 32'(e.oc));
        end
      end
    end
  end

  initial begin
    // Reset state
    step();
    step();
    @(negedge clk);
    check("rst_wr_valid", 32'(rs_wr_valid_o), 32'd0);
    check("rst_dis_ready", 32'(dis_ready_o), 32'd1);
    check("rst_base", 32'({rs_base_o}), 32'd0);
    check("rst_oc", 32'({rs_oc_o}), 32'd0);
    step();
    a_rst_n = 1'b1;
    exp_rdy(1'b1);

    // All ready: A->bank0, B->bank1, rr stays 0
    step(); set_grp(2'b11, 1, 2); exp_rdy(1'b1);
    step(); set_grp(2'b00, 0, 0); exp_wr(0, 1); exp_wr(1, 2); exp_rdy(1'b1);

    // Only bank1 ready: A->bank1, B held; then B->bank0
    step(); set_grp(2'b11, 1, 2); exp_rdy(1'b1);
    step(); set_grp(2'b00, 0, 0); rs_wr_ready_i = 2'b10; exp_wr(1, 1); exp_rdy(1'b0);
    step(); rs_wr_ready_i = 2'b11; exp_wr(0, 2); exp_rdy(1'b1);

    // rr now 1: stall three cycles, then C->bank1, D->bank0
    step(); set_grp(2'b11, 3, 4); exp_rdy(1'b1);
    step(); set_grp(2'b00, 0, 0); rs_wr_ready_i = 2'b00; exp_rdy(1'b0);
    step(); exp_rdy(1'b0);
    step(); exp_rdy(1'b0);
    step(); rs_wr_ready_i = 2'b11; exp_wr(0, 4); exp_wr(1, 3); exp_rdy(1'b1);

    // Hole at slot0: only F written, to bank rr=1
    step(); set_grp(2'b10, 5, 6); exp_rdy(1'b1);
    step(); set_grp(2'b00, 0, 0); exp_wr(1, 6); exp_rdy(1'b1);

    // Flush with B pending and a new group offered
    step(); set_grp(2'b11, 1, 2); exp_rdy(1'b1);
    step(); set_grp(2'b00, 0, 0); rs_wr_ready_i = 2'b01; exp_wr(0, 1); exp_rdy(1'b0);
    step(); flush_i = 1'b1; set_grp(2'b11, 3, 4); rs_wr_ready_i = 2'b11; exp_rdy(1'b0);
    step(); flush_i = 1'b0; set_grp(2'b00, 0, 0); exp_rdy(1'b1);

    // rr back at 0 after flush; back-to-back drain and accept
    step(); set_grp(2'b11, 3, 4); exp_rdy(1'b1);
    step(); set_grp(2'b11, 5, 6); exp_wr(0, 3); exp_wr(1, 4); exp_rdy(1'b1);
    step(); set_grp(2'b00, 0, 0); exp_wr(0, 5); exp_wr(1, 6); exp_rdy(1'b1);

    // Reset mid-drain discards the pending group
    step(); set_grp(2'b11, 1, 2); exp_rdy(1'b1);
    step(); set_grp(2'b00, 0, 0); rs_wr_ready_i = 2'b00; exp_rdy(1'b0);
    step(); a_rst_n = 1'b0; rs_wr_ready_i = 2'b11; exp_rdy(1'b1);
    step(); a_rst_n = 1'b1; exp_rdy(1'b1);
    step(); exp_rdy(1'b1);
    step();
    step();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
